efuse_read_seq: RTL and testbench
=================================

Name: efuse_read_seq

Overview:
Read-side timing sequencer that services read requests from the eFuse controller. It accepts a read_start pulse plus a word select and reads NR bits serially from the 256-bit eFuse macro. It generates the macro CSB/LOAD/STROBE/address timing and returns read_data, a read_done pulse and a busy flag. It sits between the controller and the macro read pins; the write path is a separate block.

Parameters:
NR, 64, word width per read; power of 2, 1..256; 256/NR selectable words.
T_SETUP, 2, clk cycles address/CSB/LOAD setup before STROBE; >=1.
T_STROBE, 4, clk cycles STROBE high per bit; >=1.
T_HOLD, 2, clk cycles hold after STROBE falls per bit; >=1.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
read_start  in  1  single-cycle request pulse from controller
efuse_read_sel  in  $clog2(256/NR)  word select, sampled with an accepted read_start
read_done  out  1  single-cycle completion pulse
read_data  out  NR  read word; bit i = macro bit sel*NR+i
efuse_busy_read  out  1  access in progress
efuse_csb  out  1  macro chip select, active low
efuse_load  out  1  macro read-load enable
efuse_strobe  out  1  macro sense strobe
efuse_pgenb  out  1  program enable bar; constant 1
efuse_addr  out  8  macro bit address
efuse_dout  in  1  macro sensed bit

Behaviour:
- All registers are reset synchronously on a clk edge with rst_n=0. Outputs are registered.
- Reset values: read_done=0, read_data=0, efuse_busy_read=0, efuse_csb=1, efuse_load=0, efuse_strobe=0, efuse_pgenb=1, efuse_addr=0.
- FSM states: IDLE, SETUP, STROBE, HOLD, DONE.
- IDLE:
  - read_start=1 → latch sel, bit_idx=0, go to SETUP.
  - On the following cycle: busy=1, csb=0, load=1, addr={sel,bit_idx}.
  - read_start with busy=1 (any state other than IDLE) is ignored, with no side effect.
- SETUP: hold for T_SETUP cycles, then go to STROBE.
- STROBE: strobe=1 for T_STROBE cycles. efuse_dout is captured into shadow[bit_idx] on the last STROBE cycle. Then go to HOLD with strobe=0.
- HOLD: hold for T_HOLD cycles.
  - If bit_idx < NR-1: bit_idx+1, addr updates, go to SETUP.
  - Otherwise go to DONE.
- DONE: lasts one cycle.
  - read_done=1.
  - read_data is loaded from shadow in the same cycle read_done rises.
  - csb=1, load=0, busy=0; return to IDLE.
- read_data holds its value until the next read_done. It is never partially updated.
- Latency: read_done is high exactly 1+NR*(T_SETUP+T_STROBE+T_HOLD) cycles after the read_start cycle. Defaults give 513.
- Back-to-back: read_start in the cycle after read_done is accepted.
- Timing counter: width $clog2(max(T_SETUP,T_STROBE,T_HOLD)+1). It reloads on every state entry and never wraps.
- bit_idx: width $clog2(NR), minimum 1. The address is {sel, bit_idx[..]} and is zero-extended to 8 bits.
- Reset mid-access: all outputs return to reset values at the next edge. No read_done is issued, and the partial shadow is discarded.
- Elaboration check: illegal NR or a T_* value of 0 causes a fatal error.

Optional Feature:
EFUSE_READ_MARGIN_EN
- Defined:
  - Adds input rg_efuse_margin (1b), sampled with an accepted read_start.
  - Adds output efuse_margin (1b, reset 0), driven with the sampled value for the whole access and cleared in DONE.
  - When margin=1, STROBE lasts 2*T_STROBE cycles and the latency formula uses 2*T_STROBE.
- Undefined: no margin ports; timing exactly as above.

Decomposition:
- Package efuse_pkg holds:
  - the rd_state_t enum {IDLE,SETUP,STROBE,HOLD,DONE};
  - EFUSE_BITS=256;
  - default T_SETUP/T_STROBE/T_HOLD constants;
  - the address-width constant 8.
- No sub-module; the phase counter and FSM stay in one module.

Test Plan:
- Reset held 3 cycles → csb=1, load=0, strobe=0, pgenb=1, busy=0, read_done=0, read_data=0.
- Read, NR=8, defaults, sel=3, macro bits 24..31 = 0xA5 LSB-first:
  - read_data=8'hA5 with read_done at cycle 65;
  - addr steps 24..31;
  - 8 strobe pulses of 4 cycles each.
- Read busy, NR=8, sel=3: read_start with sel=5 at cycle 20 → ignored; result still 0xA5 at cycle 65; no extra read_done.
- Back-to-back, NR=8: sel=0 (bits 0xFF) then read_start with sel=31 (bits 0x00) in the cycle after read_done → done at cycles 65 and 131; read_data 0xFF then 0x00.
- Reset mid-access: rst_n low at bit 4 of a read → outputs idle next edge; no read_done; read_data keeps its pre-reset-cleared value 0.
- With EFUSE_READ_MARGIN_EN, NR=8, margin=1: strobe pulses 8 cycles; read_done at cycle 97; efuse_margin=1 throughout.

Source files
------------

// File: rtl/efuse_pkg.sv
// Shared constants and state encoding for the eFuse read-side sequencer.
package efuse_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        HOLD   = 3'd3,
        DONE   = 3'd4
    } rd_state_t;

    localparam int EFUSE_BITS     = 256;
    localparam int ADDR_W         = 8;
    localparam int T_SETUP_DEF    = 2;
    localparam int T_STROBE_DEF   = 4;
    localparam int T_HOLD_DEF     = 2;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/efuse_read_seq.sv
// Serial eFuse read sequencer: drives CSB/LOAD/STROBE/address and assembles one NR-bit word.
// Optional build macro EFUSE_READ_MARGIN_EN adds a margin read with doubled STROBE width.
module efuse_read_seq
    import efuse_pkg::*;
#(
    parameter int NR       = 64,
    parameter int T_SETUP  = T_SETUP_DEF,
    parameter int T_STROBE = T_STROBE_DEF,
    parameter int T_HOLD   = T_HOLD_DEF,
    localparam int SEL_W   = (NR >= EFUSE_BITS) ? 1 : $clog2(EFUSE_BITS / NR)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             read_start,
    input  logic [SEL_W-1:0] efuse_read_sel,
`ifdef EFUSE_READ_MARGIN_EN
    input  logic             rg_efuse_margin,
    output logic             efuse_margin,
`endif
    output logic             read_done,
    output logic [NR-1:0]    read_data,
    output logic             efuse_busy_read,
    output logic             efuse_csb,
    output logic             efuse_load,
    output logic             efuse_strobe,
    output logic             efuse_pgenb,
    output logic [ADDR_W-1:0] efuse_addr,
    input  logic             efuse_dout
);

    if (NR < 1 || NR > EFUSE_BITS || (NR & (NR - 1)) != 0 ||
        T_SETUP < 1 || T_STROBE < 1 || T_HOLD < 1) begin : g_bad_param
        $fatal(1, "efuse_read_seq: illegal NR or zero T_* parameter");
    end

`ifdef EFUSE_READ_MARGIN_EN
    localparam int STROBE_MAX = 2 * T_STROBE;
`else
    localparam int STROBE_MAX = T_STROBE;
`endif
    localparam int CNT_W  = $clog2(max3(T_SETUP, STROBE_MAX, T_HOLD) + 1);
    localparam int IDX_W  = (NR > 1) ? $clog2(NR) : 1;
    localparam int LOG_NR = $clog2(NR);

    localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(T_STROBE - 1);
    localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(T_HOLD - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NR - 1);

    localparam logic [2:0] ST_IDLE   = IDLE;
    localparam logic [2:0] ST_SETUP  = SETUP;
    localparam logic [2:0] ST_STROBE = STROBE;
    localparam logic [2:0] ST_HOLD   = HOLD;
    localparam logic [2:0] ST_DONE   = DONE;

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] bit_idx;
    logic [SEL_W-1:0] sel_q;
    logic [NR-1:0]    shadow;
    logic [CNT_W-1:0] strobe_ld;
    logic [IDX_W-1:0] next_idx;

    // Word base is sel*NR; with NR=256 the select field shifts out entirely.
    function automatic logic [ADDR_W-1:0] make_addr(input logic [SEL_W-1:0] s,
                                                    input logic [IDX_W-1:0] i);
        return (ADDR_W'(s) << LOG_NR) | ADDR_W'(i);
    endfunction

    assign efuse_pgenb = 1'b1;
    assign next_idx    = bit_idx + 1'b1;

`ifdef EFUSE_READ_MARGIN_EN
    localparam logic [CNT_W-1:0] STROBE2_LD = CNT_W'(2 * T_STROBE - 1);

    always_comb begin
        strobe_ld = STROBE_LD;
        if (efuse_margin) strobe_ld = STROBE2_LD;
    end
`else
    always_comb begin
        strobe_ld = STROBE_LD;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            cnt             <= '0;
            bit_idx         <= '0;
            sel_q           <= '0;
            // NOTE: shadow is cleared too, so a word cut short by reset cannot leak into read_data.
            shadow          <= '0;
            read_done       <= 1'b0;
            read_data       <= '0;
            efuse_busy_read <= 1'b0;
            efuse_csb       <= 1'b1;
            efuse_load      <= 1'b0;
            efuse_strobe    <= 1'b0;
            efuse_addr      <= '0;
`ifdef EFUSE_READ_MARGIN_EN
            efuse_margin    <= 1'b0;
`endif
        end else begin
            // NOTE: default-low here makes read_done a one-cycle pulse without extra decode.
            read_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (read_start) begin
                        sel_q           <= efuse_read_sel;
                        bit_idx         <= '0;
                        cnt             <= SETUP_LD;
                        state           <= ST_SETUP;
                        efuse_busy_read <= 1'b1;
                        efuse_csb       <= 1'b0;
                        efuse_load      <= 1'b1;
                        efuse_addr      <= make_addr(efuse_read_sel, '0);
`ifdef EFUSE_READ_MARGIN_EN
                        efuse_margin    <= rg_efuse_margin;
`endif
                    end
                end
                ST_SETUP: begin
                    if (cnt == '0) begin
                        cnt          <= strobe_ld;
                        efuse_strobe <= 1'b1;
                        state        <= ST_STROBE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_STROBE: begin
                    if (cnt == '0) begin
                        shadow[bit_idx] <= efuse_dout;
                        efuse_strobe    <= 1'b0;
                        cnt             <= HOLD_LD;
                        state           <= ST_HOLD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (bit_idx != LAST_IDX) begin
                        bit_idx    <= next_idx;
                        efuse_addr <= make_addr(sel_q, next_idx);
                        cnt        <= SETUP_LD;
                        state      <= ST_SETUP;
                    end else begin
                        read_done       <= 1'b1;
                        read_data       <= shadow;
                        efuse_busy_read <= 1'b0;
                        efuse_csb       <= 1'b1;
                        efuse_load      <= 1'b0;
`ifdef EFUSE_READ_MARGIN_EN
                        efuse_margin    <= 1'b0;
`endif
                        state           <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_efuse_read_seq.sv
// Scoreboard bench for efuse_read_seq at NR=8 with default timing; margin test when EFUSE_READ_MARGIN_EN is set.
module tb_efuse_read_seq;
    import efuse_pkg::*;

    localparam int NR    = 8;
    localparam int SEL_W = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             read_start = 1'b0;
    logic [SEL_W-1:0] efuse_read_sel = '0;
    logic             read_done;
    logic [NR-1:0]    read_data;
    logic             efuse_busy_read;
    logic             efuse_csb;
    logic             efuse_load;
    logic             efuse_strobe;
    logic             efuse_pgenb;
    logic [7:0]       efuse_addr;
    logic             efuse_dout;
`ifdef EFUSE_READ_MARGIN_EN
    logic             rg_efuse_margin = 1'b0;
    logic             efuse_margin;
`endif

    logic [255:0] fuse;

    typedef struct {
        logic [NR-1:0] data;
        int            cyc;
        int            base;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int done_cnt = 0;
    int pulse_cnt = 0;
    int run_len = 0;
    int exp_strobe_w = 4;
    int exp_lat = 65;

    efuse_read_seq #(.NR(NR)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .read_start      (read_start),
        .efuse_read_sel  (efuse_read_sel),
`ifdef EFUSE_READ_MARGIN_EN
        .rg_efuse_margin (rg_efuse_margin),
        .efuse_margin    (efuse_margin),
`endif
        .read_done       (read_done),
        .read_data       (read_data),
        .efuse_busy_read (efuse_busy_read),
        .efuse_csb       (efuse_csb),
        .efuse_load      (efuse_load),
        .efuse_strobe    (efuse_strobe),
        .efuse_pgenb     (efuse_pgenb),
        .efuse_addr      (efuse_addr),
        .efuse_dout      (efuse_dout)
    );

    always #5 clk = ~clk;

    // Macro model: a bit is only sensed while selected, loaded and strobed.
    assign efuse_dout = (efuse_strobe && !efuse_csb && efuse_load) ? fuse[efuse_addr] : 1'b0;

    // One clock: observe at the falling edge, then advance past the rising edge.
    task automatic step();
        exp_t e;
        @(negedge clk);
        if (!rst_n) begin
            run_len   = 0;
            pulse_cnt = 0;
        end else begin
            if (efuse_strobe) begin
                if (run_len == 0) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL strobe_unexpected cyc=%0d addr=%0d", cyc, efuse_addr);
                    end else if (efuse_addr !== 8'(exp_q[0].base + pulse_cnt) ||
                                 efuse_csb !== 1'b0 || efuse_load !== 1'b1) begin
                        n_fail++;
                        $display("FAIL strobe_addr cyc=%0d got addr=%0d csb=%b load=%b want addr=%0d csb=0 load=1",
                                 cyc, efuse_addr, efuse_csb, efuse_load, exp_q[0].base + pulse_cnt);
                    end
                    pulse_cnt++;
                end
                run_len++;
            end else if (run_len != 0) begin
                n_checks++;
                if (run_len != exp_strobe_w) begin
                    n_fail++;
                    $display("FAIL strobe_width cyc=%0d got %0d want %0d", cyc, run_len, exp_strobe_w);
                end
                run_len = 0;
            end
            if (read_done) begin
                done_cnt++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL done_unexpected cyc=%0d data=%h", cyc, read_data);
                end else begin
                    e = exp_q.pop_front();
                    if (read_data !== e.data) begin
                        n_fail++;
                        $display("FAIL done_data cyc=%0d got %h want %h", cyc, read_data, e.data);
                    end
                    n_checks++;
                    if (cyc != e.cyc) begin
                        n_fail++;
                        $display("FAIL done_cycle got %0d want %0d", cyc, e.cyc);
                    end
                    n_checks++;
                    if (pulse_cnt != NR) begin
                        n_fail++;
                        $display("FAIL strobe_count got %0d want %0d", pulse_cnt, NR);
                    end
                    n_checks++;
                    if (efuse_busy_read !== 1'b0 || efuse_csb !== 1'b1 || efuse_load !== 1'b0 ||
                        efuse_pgenb !== 1'b1) begin
                        n_fail++;
                        $display("FAIL done_pins got busy=%b csb=%b load=%b pgenb=%b want 0 1 0 1",
                                 efuse_busy_read, efuse_csb, efuse_load, efuse_pgenb);
                    end
                end
            end
            if (!efuse_busy_read) pulse_cnt = 0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic start_read(input logic [SEL_W-1:0] s, input logic m, input logic push);
        exp_t e;
        read_start     = 1'b1;
        efuse_read_sel = s;
`ifdef EFUSE_READ_MARGIN_EN
        rg_efuse_margin = m;
`else
        if (m) $display("margin requested without margin build");
`endif
        if (push) begin
            e.data = fuse[int'(s) * NR +: NR];
            e.cyc  = cyc + exp_lat;
            e.base = int'(s) * NR;
            exp_q.push_back(e);
        end
        step();
        read_start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout pending=%0d after %0d cycles", exp_q.size(), budget);
            exp_q.delete();
        end
    endtask

    task automatic check_idle_pins(input string tag);
        n_checks++;
        if (efuse_csb !== 1'b1 || efuse_load !== 1'b0 || efuse_strobe !== 1'b0 ||
            efuse_pgenb !== 1'b1 || efuse_busy_read !== 1'b0 || read_done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_pins got csb=%b load=%b strobe=%b pgenb=%b busy=%b done=%b want 1 0 0 1 0 0",
                     tag, efuse_csb, efuse_load, efuse_strobe, efuse_pgenb, efuse_busy_read, read_done);
        end
        n_checks++;
        if (read_data !== '0 || efuse_addr !== 8'd0) begin
            n_fail++;
            $display("FAIL %s_data got data=%h addr=%0d want 0 0", tag, read_data, efuse_addr);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        check_idle_pins("reset");
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic_read();
        start_read(5'd3, 1'b0, 1'b1);
        wait_done(200);
        step();
        n_checks++;
        if (read_data !== 8'hA5) begin
            n_fail++;
            $display("FAIL basic_hold got %h want a5", read_data);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        int d0;
        start_read(5'd3, 1'b0, 1'b1);
        while (pulse_cnt < 5 && n < 200) begin
            step();
            n++;
        end
        n_checks++;
        if (pulse_cnt < 5) begin
            n_fail++;
            $display("FAIL mid_reach got pulses=%0d want 5", pulse_cnt);
        end
        rst_n = 1'b0;
        step();
        check_idle_pins("mid_reset");
        exp_q.delete();
        d0 = done_cnt;
        rst_n = 1'b1;
        repeat (100) step();
        n_checks++;
        if (done_cnt != d0 || read_data !== '0) begin
            n_fail++;
            $display("FAIL mid_no_done got dones=%0d data=%h want %0d 00", done_cnt, read_data, d0);
        end
    endtask

    task automatic test_busy_ignore();
        int c0;
        int d0;
        c0 = cyc;
        start_read(5'd3, 1'b0, 1'b1);
        while (cyc < c0 + 20) step();
        start_read(5'd5, 1'b0, 1'b0);
        wait_done(200);
        n_checks++;
        if (read_data !== 8'hA5) begin
            n_fail++;
            $display("FAIL busy_data got %h want a5", read_data);
        end
        d0 = done_cnt;
        repeat (80) step();
        n_checks++;
        if (done_cnt != d0) begin
            n_fail++;
            $display("FAIL busy_extra_done got %0d want %0d", done_cnt, d0);
        end
    endtask

    task automatic test_back_to_back();
        start_read(5'd0, 1'b0, 1'b1);
        repeat (65) step();
        n_checks++;
        if (exp_q.size() != 0 || read_data !== 8'hFF) begin
            n_fail++;
            $display("FAIL b2b_first got pending=%0d data=%h want 0 ff", exp_q.size(), read_data);
        end
        start_read(5'd31, 1'b0, 1'b1);
        wait_done(200);
        n_checks++;
        if (read_data !== 8'h00) begin
            n_fail++;
            $display("FAIL b2b_second got %h want 00", read_data);
        end
    endtask

`ifdef EFUSE_READ_MARGIN_EN
    task automatic test_margin();
        int bad = 0;
        int n = 0;
        exp_strobe_w = 8;
        exp_lat      = 97;
        start_read(5'd3, 1'b1, 1'b1);
        rg_efuse_margin = 1'b0;
        while (exp_q.size() != 0 && n < 300) begin
            if (efuse_busy_read && efuse_margin !== 1'b1) bad++;
            step();
            n++;
        end
        wait_done(10);
        n_checks++;
        if (bad != 0 || efuse_margin !== 1'b0) begin
            n_fail++;
            $display("FAIL margin_flag got bad=%0d final=%b want 0 0", bad, efuse_margin);
        end
        exp_strobe_w = 4;
        exp_lat      = 65;
    endtask
`endif

    initial begin
        fuse = '0;
        fuse[0 +: 8]   = 8'hFF;
        fuse[24 +: 8]  = 8'hA5;
        fuse[40 +: 8]  = 8'h3C;
        fuse[248 +: 8] = 8'h00;
        fuse[100 +: 8] = 8'h5A;

        test_reset();
        test_basic_read();
        test_reset_mid();
        test_busy_ignore();
        test_back_to_back();
`ifdef EFUSE_READ_MARGIN_EN
        test_margin();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
